// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU operator codes, RV32I decode constants and the
// layout of the bundle handed from the issue stage to the ALU.
package alu_issue_pkg;

    localparam int ALU_OP_WIDTH = 4;

    // ALU operator codes; the branch comparisons share the ALU with arithmetic.
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9,
        ALU_OP_SEQ  = 4'd10,
        ALU_OP_SNE  = 4'd11,
        ALU_OP_SGE  = 4'd12,
        ALU_OP_SGEU = 4'd13
    } aluOp_e;

    // RV32I major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values for OP / OP-IMM.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 values for BRANCH.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BRSV0 = 3'b010;
    localparam logic [2:0] F3_BRSV1 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 values: base encoding and the SUB/SRA alternate.
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Everything the ALU and writeback need for one instruction.
    typedef struct packed {
        aluOp_e      aluOp;
        logic [31:0] imm;
        logic [31:0] operand1;
        logic [31:0] operand2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        isBranch;
        logic        illegal;
    } issueBundle_t;

    localparam int BUNDLE_WIDTH = $bits(issueBundle_t);

    // Arithmetic operator for OP / OP-IMM; alt selects SUB or SRA.
    function automatic aluOp_e arithOp(input logic [2:0] funct3, input logic alt);
        aluOp_e op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            F3_SLL:     op = ALU_OP_SLL;
            F3_SLT:     op = ALU_OP_SLT;
            F3_SLTU:    op = ALU_OP_SLTU;
            F3_XOR:     op = ALU_OP_XOR;
            F3_SRL_SRA: op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            F3_OR:      op = ALU_OP_OR;
            default:    op = ALU_OP_AND;
        endcase
        return op;
    endfunction

    // Comparison operator for BRANCH; reserved funct3 values fall back to ADD.
    function automatic aluOp_e branchOp(input logic [2:0] funct3);
        aluOp_e op;
        case (funct3)
            F3_BEQ:  op = ALU_OP_SEQ;
            F3_BNE:  op = ALU_OP_SNE;
            F3_BLT:  op = ALU_OP_SLT;
            F3_BGE:  op = ALU_OP_SGE;
            F3_BLTU: op = ALU_OP_SLTU;
            F3_BGEU: op = ALU_OP_SGEU;
            default: op = ALU_OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_skid_buffer.sv
// skid_buffer: two-entry register slice. The main entry drives the output;
// the skid entry catches a beat that arrives while main is stalled, which
// lets in_ready come straight from a flop.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_mainValid;
    logic [WIDTH-1:0] r_mainData;
    logic             r_skidValid;
    logic [WIDTH-1:0] r_skidData;
    logic             w_accept;
    logic             w_consume;

    assign in_ready  = !r_skidValid;
    assign out_valid = r_mainValid;
    assign out_data  = r_mainData;
    assign w_accept  = in_valid && !r_skidValid;
    assign w_consume = r_mainValid && out_ready;

    // Advance the two entries in FIFO order; flush wipes both and drops the incoming beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (r_mainValid && !w_consume) begin
            if (w_accept) begin
                r_skidValid <= 1'b1;
                r_skidData  <= in_data;
            end
        end else if (r_skidValid) begin
            r_mainValid <= 1'b1;
            r_mainData  <= r_skidData;
            r_skidValid <= 1'b0;
        end else if (w_accept) begin
            r_mainValid <= 1'b1;
            r_mainData  <= in_data;
        end else begin
            r_mainValid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes one RV32I instruction per beat into the ALU input
// bundle and registers it through a skid buffer.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pc,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ALU_OP_WIDTH-1:0] out_operator,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_operand1,
    output logic [XLEN-1:0]         out_operand2,
    output logic [XLEN-1:0]         out_pc,
    output logic [4:0]              out_rd,
    output logic                    out_we,
    output logic                    out_is_branch,
    output logic                    out_illegal
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [4:0]   w_rd;
    logic [31:0]  w_immI;
    logic [31:0]  w_immB;
    logic [31:0]  w_immU;
    logic         w_legal;
    logic         w_writesRd;
    issueBundle_t w_decoded;
    issueBundle_t w_outBundle;

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];
    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];
    assign w_rd     = in_inst[11:7];
    assign w_immI   = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_immB   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_immU   = {in_inst[31:12], 12'b0};

    // Decode the incoming instruction; unsupported encodings collapse to a zeroed ADD.
    always_comb begin
        w_decoded       = '0;
        w_decoded.aluOp = ALU_OP_ADD;
        w_decoded.pc    = in_pc;
        w_decoded.rd    = w_rd;
        w_legal         = 1'b0;
        w_writesRd      = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_decoded.aluOp    = arithOp(w_funct3, w_funct7 == F7_ALT);
                w_decoded.imm      = {27'b0, rs2_data[4:0]};
                w_decoded.operand1 = rs1_data;
                w_decoded.operand2 = rs2_data;
                w_writesRd         = 1'b1;
                w_legal            = (w_funct7 == F7_BASE) ||
                                     ((w_funct7 == F7_ALT) &&
                                      ((w_funct3 == F3_ADD_SUB) || (w_funct3 == F3_SRL_SRA)));
            end
            OPC_OP_IMM: begin
                w_decoded.aluOp    = arithOp(w_funct3, (w_funct3 == F3_SRL_SRA) && (w_funct7 == F7_ALT));
                w_decoded.imm      = w_immI;
                w_decoded.operand1 = rs1_data;
                w_decoded.operand2 = w_immI;
                w_writesRd         = 1'b1;
                case (w_funct3)
                    F3_SLL:     w_legal = (w_funct7 == F7_BASE);
                    F3_SRL_SRA: w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                    default:    w_legal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                w_decoded.aluOp    = branchOp(w_funct3);
                w_decoded.imm      = w_immB;
                w_decoded.operand1 = rs1_data;
                w_decoded.operand2 = rs2_data;
                w_decoded.isBranch = 1'b1;
                w_legal            = (w_funct3 != F3_BRSV0) && (w_funct3 != F3_BRSV1);
            end
            OPC_LUI: begin
                w_decoded.imm      = w_immU;
                w_decoded.operand2 = w_immU;
                w_writesRd         = 1'b1;
                w_legal            = 1'b1;
            end
            OPC_AUIPC: begin
                w_decoded.imm      = w_immU;
                w_decoded.operand1 = in_pc;
                w_decoded.operand2 = w_immU;
                w_writesRd         = 1'b1;
                w_legal            = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (!w_legal) begin
            w_decoded.aluOp    = ALU_OP_ADD;
            w_decoded.imm      = '0;
            w_decoded.operand1 = '0;
            w_decoded.operand2 = '0;
            w_decoded.isBranch = 1'b0;
        end
        w_decoded.illegal = !w_legal;
        w_decoded.we      = w_legal && w_writesRd && (w_rd != 5'd0);
    end

    skid_buffer #(
        .WIDTH (BUNDLE_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_decoded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_outBundle)
    );

    assign out_operator  = w_outBundle.aluOp;
    assign out_imm       = w_outBundle.imm;
    assign out_operand1  = w_outBundle.operand1;
    assign out_operand2  = w_outBundle.operand2;
    assign out_pc        = w_outBundle.pc;
    assign out_rd        = w_outBundle.rd;
    assign out_we        = w_outBundle.we;
    assign out_is_branch = w_outBundle.isBranch;
    assign out_illegal   = w_outBundle.illegal;

endmodule
